// File: rtl/ibex_hpm_counter_bank.sv
// Machine counter bank for the CSR file: mcycle, minstret, mhpmcounter3..N+2,
// mhpmevent masks, mcountinhibit and one-cycle overflow pulses.
module ibex_hpm_counter_bank #(
  parameter int unsigned MHPMCounterNum   = 10,
  parameter int unsigned MHPMCounterWidth = 40,
  parameter int unsigned NumEvents        = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 csr_we_i,
  input  logic [11:0]          csr_addr_i,
  input  logic [31:0]          csr_wdata_i,
  output logic [31:0]          csr_rdata_o,
  output logic                 csr_hit_o,
  input  logic                 instr_ret_i,
  input  logic [NumEvents-1:0] event_i,
  input  logic                 debug_stop_i,
  output logic [31:0]          ovf_o
);

  function automatic logic [31:0] impl_mask();
    logic [31:0] m;
    m = 32'h0000_0005;
    for (int unsigned i = 3; i < 3 + MHPMCounterNum; i++) begin
      m[i] = 1'b1;
    end
    return m;
  endfunction

  localparam logic [31:0] ImplMask = impl_mask();

  logic [4:0]        idx;
  logic              is_evt_page;
  logic              is_lo_page;
  logic              is_hi_page;
  logic              wr_en;
  logic              wr_inhibit;
  logic [31:0]       inhibit_q;
  logic [31:0][63:0] cnt_val;
  logic [31:0][31:0] evt_val;

  assign idx         = csr_addr_i[4:0];
  assign is_evt_page = (csr_addr_i[11:5] == 7'h19);
  assign is_lo_page  = (csr_addr_i[11:5] == 7'h58);
  assign is_hi_page  = (csr_addr_i[11:5] == 7'h5C);

  // Offsets 1 and 2 of the 0x320 page are not ours; offset 1 of the counter pages is 'time'.
  assign csr_hit_o = (is_evt_page && (idx == 5'd0 || idx >= 5'd3)) ||
                     ((is_lo_page || is_hi_page) && idx != 5'd1);

  assign wr_en      = csr_we_i && csr_hit_o;
  assign wr_inhibit = wr_en && is_evt_page && (idx == 5'd0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inhibit_q <= '0;
    end else if (wr_inhibit) begin
      inhibit_q <= csr_wdata_i & ImplMask;
    end
  end

  for (genvar i = 0; i < 32; i++) begin : g_ctr
    if (ImplMask[i]) begin : g_impl
      localparam int unsigned CW = (i < 3) ? 64 : MHPMCounterWidth;

      logic [CW-1:0] cnt_q;
      logic [CW-1:0] cnt_d;
      logic [CW-1:0] lo_val;
      logic [CW-1:0] hi_val;
      logic          ovf_q;
      logic          ovf_d;
      logic          inc;
      logic          wr_lo;
      logic          wr_hi;
      logic          hi_writable;

      assign wr_lo = wr_en && is_lo_page && (idx == 5'(i));
      assign wr_hi = wr_en && is_hi_page && (idx == 5'(i)) && hi_writable;

      if (CW > 32) begin : g_wide
        assign hi_writable = 1'b1;
        assign lo_val      = {cnt_q[CW-1:32], csr_wdata_i};
        assign hi_val      = {csr_wdata_i[CW-33:0], cnt_q[31:0]};
      end else begin : g_narrow
        assign hi_writable = 1'b0;
        assign lo_val      = csr_wdata_i[CW-1:0];
        assign hi_val      = cnt_q;
      end

      if (i == 0) begin : g_cycle
        assign inc        = !inhibit_q[0] && !debug_stop_i;
        assign evt_val[i] = '0;
      end else if (i == 2) begin : g_instret
        assign inc        = instr_ret_i && !inhibit_q[2] && !debug_stop_i;
        assign evt_val[i] = '0;
      end else begin : g_hpm
        logic [NumEvents-1:0] evt_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
          if (!rst_ni) begin
            evt_q <= '0;
          end else if (wr_en && is_evt_page && (idx == 5'(i))) begin
            evt_q <= csr_wdata_i[NumEvents-1:0];
          end
        end

        // Any selected event counts once per cycle, however many are set.
        assign inc        = (|(event_i & evt_q)) && !inhibit_q[i] && !debug_stop_i;
        assign evt_val[i] = 32'(evt_q);
      end

      // A software write to either half takes priority over this cycle's increment.
      always_comb begin
        cnt_d = cnt_q;
        ovf_d = 1'b0;
        if (wr_lo) begin
          cnt_d = lo_val;
        end else if (wr_hi) begin
          cnt_d = hi_val;
        end else if (inc) begin
          cnt_d = cnt_q + CW'(1);
          ovf_d = &cnt_q;
        end
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          cnt_q <= '0;
          ovf_q <= 1'b0;
        end else begin
          cnt_q <= cnt_d;
          ovf_q <= ovf_d;
        end
      end

      assign cnt_val[i] = 64'(cnt_q);
      assign ovf_o[i]   = ovf_q;
    end else begin : g_unimpl
      assign cnt_val[i] = '0;
      assign evt_val[i] = '0;
      assign ovf_o[i]   = 1'b0;
    end
  end

  always_comb begin
    csr_rdata_o = '0;
    if (csr_hit_o) begin
      if (is_evt_page) begin
        csr_rdata_o = (idx == 5'd0) ? inhibit_q : evt_val[idx];
      end else if (is_lo_page) begin
        csr_rdata_o = cnt_val[idx][31:0];
      end else begin
        csr_rdata_o = cnt_val[idx][63:32];
      end
    end
  end

endmodule

// File: tb/tb_ibex_hpm_counter_bank.sv
// Scoreboard bench for ibex_hpm_counter_bank: stimulus queues expectations,
// a negedge monitor pops and compares them against the live outputs.
module tb_ibex_hpm_counter_bank;

  logic        clk_i;
  logic        rst_ni;
  logic        csr_we_i;
  logic [11:0] csr_addr_i;
  logic [31:0] csr_wdata_i;
  logic [31:0] csr_rdata_o;
  logic        csr_hit_o;
  logic        instr_ret_i;
  logic [15:0] event_i;
  logic        debug_stop_i;
  logic [31:0] ovf_o;

  ibex_hpm_counter_bank #(
    .MHPMCounterNum  (10),
    .MHPMCounterWidth(40),
    .NumEvents       (16)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .csr_we_i    (csr_we_i),
    .csr_addr_i  (csr_addr_i),
    .csr_wdata_i (csr_wdata_i),
    .csr_rdata_o (csr_rdata_o),
    .csr_hit_o   (csr_hit_o),
    .instr_ret_i (instr_ret_i),
    .event_i     (event_i),
    .debug_stop_i(debug_stop_i),
    .ovf_o       (ovf_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // kind: 0 = csr_rdata_o, 1 = csr_hit_o, 2 = ovf_o
  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t sb[$];
  int   req_n  = 0;
  int   checks = 0;
  int   errors = 0;

  always @(negedge clk_i) begin
    for (int i = 0; i < req_n; i++) begin
      chk_t        e;
      logic [31:0] act;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow: monitor expected an entry, queue empty");
      end else begin
        e = sb.pop_front();
        case (e.kind)
          0:       act = csr_rdata_o;
          1:       act = {31'b0, csr_hit_o};
          default: act = ovf_o;
        endcase
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
    req_n = 0;
  endtask

  task automatic expect_out(input int kind, input logic [31:0] exp, input string name);
    chk_t e;
    e.kind = kind;
    e.exp  = exp;
    e.name = name;
    sb.push_back(e);
    req_n++;
  endtask

  task automatic rd(input logic [11:0] addr, input logic [31:0] exp, input string name);
    csr_addr_i = addr;
    expect_out(0, exp, name);
  endtask

  task automatic wr(input logic [11:0] addr, input logic [31:0] data);
    csr_we_i    = 1'b1;
    csr_addr_i  = addr;
    csr_wdata_i = data;
    tick();
    csr_we_i    = 1'b0;
  endtask

  initial begin
    rst_ni       = 1'b0;
    csr_we_i     = 1'b0;
    csr_addr_i   = 12'h000;
    csr_wdata_i  = '0;
    instr_ret_i  = 1'b0;
    event_i      = '0;
    debug_stop_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    // reset state; mcycle starts counting from the first edge after release
    rd(12'hB00, 32'h0, "rst_mcycle");
    expect_out(2, 32'h0, "rst_ovf");
    tick();
    rd(12'hB02, 32'h0, "rst_minstret");
    tick();
    rd(12'hB03, 32'h0, "rst_hpm3");
    tick();
    rd(12'h320, 32'h0, "rst_inhibit");
    tick();
    tick();
    rd(12'hB00, 32'h5, "mcycle_after_5");
    tick();

    // event select: +1 per cycle even with two selected events active
    wr(12'h323, 32'h0005);
    event_i = 16'h0004;
    repeat (3) tick();
    event_i = 16'h0005;
    repeat (2) tick();
    event_i = 16'h0000;
    rd(12'hB03, 32'h5, "hpm3_event_count");
    tick();
    rd(12'hB04, 32'h0, "hpm4_idle");
    tick();
    rd(12'h323, 32'h5, "mhpmevent3_readback");
    tick();
    wr(12'hB84, 32'h1FF);
    rd(12'hB84, 32'hFF, "hpm4_high_truncated");
    tick();

    // wrap at 2^40
    wr(12'hB83, 32'hFF);
    wr(12'hB03, 32'hFFFF_FFFF);
    event_i = 16'h0001;
    tick();
    event_i = 16'h0000;
    rd(12'hB03, 32'h0, "wrap_low");
    expect_out(2, 32'h0000_0008, "wrap_ovf_pulse");
    tick();
    rd(12'hB83, 32'h0, "wrap_high");
    expect_out(2, 32'h0, "wrap_ovf_single_cycle");
    tick();

    // write beats same-cycle increment
    instr_ret_i = 1'b1;
    wr(12'hB02, 32'h100);
    rd(12'hB02, 32'h100, "write_wins_n1");
    tick();
    rd(12'hB02, 32'h101, "write_then_inc_n2");
    instr_ret_i = 1'b0;
    tick();

    // inhibit mcycle only
    wr(12'h320, 32'h1);
    wr(12'hB00, 32'h1234);
    instr_ret_i = 1'b1;
    rd(12'hB00, 32'h1234, "inhibit_mcycle_a");
    repeat (3) tick();
    instr_ret_i = 1'b0;
    rd(12'hB02, 32'h104, "inhibit_minstret_counts");
    tick();
    rd(12'hB00, 32'h1234, "inhibit_mcycle_b");
    tick();

    // debug stop freezes everything
    debug_stop_i = 1'b1;
    wr(12'h320, 32'h0);
    instr_ret_i = 1'b1;
    event_i     = 16'h0001;
    repeat (3) tick();
    instr_ret_i = 1'b0;
    event_i     = 16'h0000;
    rd(12'hB00, 32'h1234, "stop_mcycle");
    tick();
    rd(12'hB02, 32'h104, "stop_minstret");
    tick();
    rd(12'hB03, 32'h0, "stop_hpm3");
    tick();
    debug_stop_i = 1'b0;

    wr(12'h320, 32'hFFFF_FFFF);
    rd(12'h320, 32'h0000_1FFD, "inhibit_writable_mask");
    tick();

    // unimplemented counters and non-hit addresses
    wr(12'hB10, 32'h55);
    wr(12'h330, 32'h7);
    rd(12'hB10, 32'h0, "unimpl_ctr_read");
    expect_out(1, 32'h1, "unimpl_ctr_hit");
    tick();
    rd(12'h330, 32'h0, "unimpl_evt_read");
    expect_out(1, 32'h1, "unimpl_evt_hit");
    tick();
    rd(12'hB01, 32'h0, "b01_read");
    expect_out(1, 32'h0, "b01_no_hit");
    tick();
    csr_addr_i = 12'hB81;
    expect_out(1, 32'h0, "b81_no_hit");
    tick();
    csr_addr_i = 12'h321;
    expect_out(1, 32'h0, "x321_no_hit");
    tick();
    tick();

    if (sb.size() != 0) begin
      errors += sb.size();
      $display("FAIL scoreboard_leftover: got %0d pending entries expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
